radio_pll_responder: RTL
========================

Name: radio_pll_responder

Overview:
- Responder end of the timing-engine handshake: consumes per-lane radioEnable/radioRxEn requests and returns pllSettled/tArstFs status.
- Models the radio/PLL side so the timing-engine stages can be closed-loop tested.
- BIT_WIDTH independent lanes, each with its own FSM and settle counter.
- Isolation clamp on the status outputs mirrors the power-domain isolation used on the stage boundaries.

Parameters:
- BIT_WIDTH, 2, number of independent lanes.
- SETTLE_CYCLES, 8, cycles from accepted enable to PLL lock (>=1).
- COOLDOWN_CYCLES, 3, cycles a lane is blocked after disable before a new enable is accepted (>=1).

Ports:
- ck  input  1  clock; all state on rising edge.
- arst  input  1  asynchronous active-low reset; low clears all state immediately.
- radioEnable  input  BIT_WIDTH  per-lane PLL/radio enable request.
- radioRxEn  input  BIT_WIDTH  per-lane receive-enable request.
- isolate  input  1  high: all status outputs clamped to 0 (combinational).
- clrErr  input  1  single-cycle pulse; clears errSticky.
- pllSettled  output  BIT_WIDTH  lane locked (LOCKED or RX).
- tArstFs  output  BIT_WIDTH  one-cycle pulse on the lock event (timer fast-settle reset).
- rxActive  output  BIT_WIDTH  lane in RX.
- errSticky  output  BIT_WIDTH  sticky protocol-violation flag per lane.

Behaviour:
- Reset (arst low, async): every lane in IDLE, counter 0, all outputs 0. Deassertion is taken synchronously by the integrator; the block needs no internal synchroniser.
- Per-lane FSM states: IDLE, RAMP, LOCKED, RX, COOLDOWN.
  - IDLE: radioEnable=1 -> RAMP, counter loaded with SETTLE_CYCLES-1.
  - RAMP:
    - Counter decrements each cycle.
    - radioEnable=0 -> COOLDOWN (abort).
    - Counter==0 with radioEnable=1 -> LOCKED.
    - pllSettled goes high exactly SETTLE_CYCLES cycles after the edge that samples radioEnable=1 in IDLE.
  - LOCKED:
    - radioEnable=0 -> COOLDOWN.
    - Otherwise radioRxEn=1 -> RX.
  - RX:
    - radioEnable=0 -> COOLDOWN (enable dominates).
    - Otherwise radioRxEn=0 -> LOCKED.
  - COOLDOWN:
    - Counter loaded with COOLDOWN_CYCLES-1 on entry and decrements each cycle.
    - Counter==0 -> IDLE; radioEnable is ignored while in COOLDOWN.
    - A held enable re-enters RAMP on the cycle after IDLE is reached.
- Outputs (registered, from state):
  - pllSettled = state in {LOCKED, RX}.
  - rxActive = state==RX.
  - tArstFs = 1 for exactly the first cycle of LOCKED entered from RAMP. No pulse on RX->LOCKED.
- errSticky[ii] is set on any cycle where radioRxEn[ii]=1 and the lane is in IDLE, RAMP or COOLDOWN.
  - The flag stays set until a clrErr cycle.
  - Set and clear in the same cycle: set wins.
- Isolation: isolate=1 forces pllSettled, tArstFs, rxActive and errSticky outputs to 0 combinationally. Internal state and counters keep running; unclamped values reappear the cycle isolate drops.
- A tArstFs pulse that occurs during isolation is lost (not deferred).
- Lanes are fully independent; there is no shared arbitration.
- Counter width: $clog2(max(SETTLE_CYCLES, COOLDOWN_CYCLES)+1). There is no wrap-around, because the counter is reloaded on every state entry.
- Reset mid-operation (any state): immediate return to IDLE; outputs go to 0 asynchronously.

Test Plan:
- Lock latency: reset, then radioEnable=2'b01 held. pllSettled[0] rises 8 cycles after the enable is sampled. tArstFs[0] is high exactly 1 cycle, coincident with the rise. Lane 1 stays 0.
- RX handshake: locked lane 0, radioRxEn[0]=1 for 4 cycles then 0.
  - rxActive[0]=1 for 4 cycles, one cycle after each request edge.
  - pllSettled stays 1; no tArstFs pulse.
- Abort and cooldown: drop radioEnable at RAMP cycle 3 and re-raise on the next cycle.
  - pllSettled remains 0 through 3 COOLDOWN cycles plus 8 RAMP cycles.
  - Lock occurs 12 cycles after the drop.
- Protocol error: radioRxEn[1]=1 while lane 1 is IDLE sets errSticky[1]=1, which persists. clrErr together with a repeat violation keeps it 1; clrErr alone clears it to 0.
- Isolation: isolate=1 while both lanes are locked forces all outputs to 0. Drop isolate 2 cycles later: pllSettled=2'b11 with no tArstFs pulse.
- Async reset: drive arst low mid-RAMP between clock edges. All outputs are 0 before the next edge. After release with enable held, the full 8-cycle ramp repeats.

Source files
------------

// File: rtl/radio_pll_responder_if.sv
// Timing-engine <-> radio/PLL responder handshake bundle.
// master = timing engine (drives requests), slave = responder (drives status).
interface radio_pll_responder_if #(
  parameter int BIT_WIDTH = 2
);
  logic [BIT_WIDTH-1:0] radioEnable;
  logic [BIT_WIDTH-1:0] radioRxEn;
  logic                 isolate;
  logic                 clrErr;
  logic [BIT_WIDTH-1:0] pllSettled;
  logic [BIT_WIDTH-1:0] tArstFs;
  logic [BIT_WIDTH-1:0] rxActive;
  logic [BIT_WIDTH-1:0] errSticky;

  modport master (
    output radioEnable, radioRxEn, isolate, clrErr,
    input  pllSettled, tArstFs, rxActive, errSticky
  );

  modport slave (
    input  radioEnable, radioRxEn, isolate, clrErr,
    output pllSettled, tArstFs, rxActive, errSticky
  );
endinterface

// File: rtl/radio_pll_responder.sv
// Radio/PLL responder model: per-lane enable -> ramp -> lock -> rx FSM with
// cooldown after disable, sticky protocol-error flags and an isolation clamp.
module radio_pll_responder #(
  parameter int BIT_WIDTH       = 2,
  parameter int SETTLE_CYCLES   = 8,
  parameter int COOLDOWN_CYCLES = 3
) (
  input logic                   ck,
  input logic                   arst,
  radio_pll_responder_if.slave  bus
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > COOLDOWN_CYCLES) ? SETTLE_CYCLES : COOLDOWN_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETTLE_LOAD   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAMP     = 3'd1,
    ST_LOCKED   = 3'd2,
    ST_RX       = 3'd3,
    ST_COOLDOWN = 3'd4
  } lane_state_e;

  logic [BIT_WIDTH-1:0] settled_v_s;
  logic [BIT_WIDTH-1:0] pulse_v_s;
  logic [BIT_WIDTH-1:0] rx_v_s;
  logic [BIT_WIDTH-1:0] err_v_s;
  logic [BIT_WIDTH-1:0] pass_s;

  for (genvar ii = 0; ii < BIT_WIDTH; ii++) begin : g_lane
    lane_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             settled_r;
    logic             pulse_r;
    logic             rx_r;
    logic             err_r;
    logic             en_s;
    logic             rx_req_s;
    logic             viol_s;

    assign en_s     = bus.radioEnable[ii];
    assign rx_req_s = bus.radioRxEn[ii];
    // An rx request is only legal once the PLL is locked.
    assign viol_s   = rx_req_s && (state_r != ST_LOCKED) && (state_r != ST_RX);

    // Lane FSM; status flags are registered alongside the state they describe.
    always_ff @(posedge ck or negedge arst) begin
      if (!arst) begin
        state_r   <= ST_IDLE;
        cnt_r     <= CNT_ZERO;
        settled_r <= 1'b0;
        pulse_r   <= 1'b0;
        rx_r      <= 1'b0;
      end else begin
        pulse_r <= 1'b0;
        case (state_r)
          ST_IDLE: begin
            if (en_s) begin
              state_r <= ST_RAMP;
              cnt_r   <= SETTLE_LOAD;
            end else begin
              cnt_r   <= CNT_ZERO;
            end
          end
          ST_RAMP: begin
            if (!en_s) begin
              state_r <= ST_COOLDOWN;
              cnt_r   <= COOLDOWN_LOAD;
            end else if (cnt_r == CNT_ZERO) begin
              state_r   <= ST_LOCKED;
              settled_r <= 1'b1;
              pulse_r   <= 1'b1;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          ST_LOCKED: begin
            if (!en_s) begin
              state_r   <= ST_COOLDOWN;
              cnt_r     <= COOLDOWN_LOAD;
              settled_r <= 1'b0;
            end else if (rx_req_s) begin
              state_r <= ST_RX;
              rx_r    <= 1'b1;
            end else begin
              state_r <= ST_LOCKED;
            end
          end
          ST_RX: begin
            if (!en_s) begin
              state_r   <= ST_COOLDOWN;
              cnt_r     <= COOLDOWN_LOAD;
              settled_r <= 1'b0;
              rx_r      <= 1'b0;
            end else if (!rx_req_s) begin
              state_r <= ST_LOCKED;
              rx_r    <= 1'b0;
            end else begin
              state_r <= ST_RX;
            end
          end
          ST_COOLDOWN: begin
            if (cnt_r == CNT_ZERO) begin
              state_r <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            settled_r <= 1'b0;
            rx_r      <= 1'b0;
          end
        endcase
      end
    end

    // Sticky error: a new violation outranks a simultaneous clear.
    always_ff @(posedge ck or negedge arst) begin
      if (!arst) begin
        err_r <= 1'b0;
      end else if (viol_s) begin
        err_r <= 1'b1;
      end else if (bus.clrErr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end

    assign settled_v_s[ii] = settled_r;
    assign pulse_v_s[ii]   = pulse_r;
    assign rx_v_s[ii]      = rx_r;
    assign err_v_s[ii]     = err_r;
  end

  // Isolation clamp is combinational so a pulse inside the window is dropped.
  assign pass_s         = {BIT_WIDTH{~bus.isolate}};
  assign bus.pllSettled = settled_v_s & pass_s;
  assign bus.tArstFs    = pulse_v_s & pass_s;
  assign bus.rxActive   = rx_v_s & pass_s;
  assign bus.errSticky  = err_v_s & pass_s;

endmodule
